// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one byte/half/word request at a time,
// issues a single read or write strobe to a word-wide memory, aligns the
// store lanes or extracts and extends the load result, and holds the
// response until it is consumed.
module lsu_ctrl #(
    parameter int unsigned LOAD_LAT = 1   // ld_wen to rdata sample, 1..7 cycles
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_misalign,
    output logic        out_illegal,
    output logic        ld_wen,
    output logic [31:0] raddr,
    input  logic [31:0] rdata,
    output logic        st_wen,
    output logic [7:0]  wmask,
    output logic [31:0] waddr,
    output logic [31:0] wdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LH  = 4'd1;
    localparam logic [3:0] OP_LW  = 4'd2;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    // Remaining WAIT cycles loaded on leaving ISSUE for multi-cycle loads.
    localparam logic [2:0] WAIT_INIT = 3'(LOAD_LAT - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] res_q, res_d;
    logic        mis_q, mis_d;
    logic        ill_q, ill_d;

    logic        in_illegal;
    logic        in_misalign;
    logic        op_is_load;
    logic [31:0] word_addr;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Shift the addressed bytes to the bottom, then sign/zero-extend by op.
    function automatic logic [31:0] extract(input logic [3:0]  op,
                                            input logic [1:0]  off,
                                            input logic [31:0] word);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        case (op)
            OP_LB:   return {{24{s[7]}}, s[7:0]};
            OP_LBU:  return {24'h0, s[7:0]};
            OP_LH:   return {{16{s[15]}}, s[15:0]};
            OP_LHU:  return {16'h0, s[15:0]};
            default: return word;
        endcase
    endfunction

    // Fault decode of the incoming request; illegal ops never report misalign.
    always_comb begin
        in_illegal  = !(is_load(in_op) || is_store(in_op));
        in_misalign = 1'b0;
        if (!in_illegal) begin
            case (in_op)
                OP_LH, OP_LHU, OP_SH: in_misalign = in_addr[0];
                OP_LW, OP_SW:         in_misalign = (in_addr[1:0] != 2'b00);
                default:              in_misalign = 1'b0;
            endcase
        end
    end

    assign op_is_load = is_load(op_q);
    assign word_addr  = {addr_q[31:2], 2'b00};

    // State register and request/response holding registers.
    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the asynchronous clear makes every output drop at once
    // because all outputs are decoded from state_q.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            op_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            res_q   <= 32'd0;
            mis_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            res_q   <= res_d;
            mis_q   <= mis_d;
            ill_q   <= ill_d;
        end
    end

    // Next-state logic and all outputs, decoded from the current state.
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        res_d        = res_q;
        mis_d        = mis_q;
        ill_d        = ill_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_rdata    = 32'd0;
        out_misalign = 1'b0;
        out_illegal  = 1'b0;
        ld_wen       = 1'b0;
        raddr        = 32'd0;
        st_wen       = 1'b0;
        wmask        = 8'd0;
        waddr        = 32'd0;
        wdata        = 32'd0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d    = in_op;
                    addr_d  = in_addr;
                    wdata_d = in_wdata;
                    res_d   = 32'd0;
                    ill_d   = in_illegal;
                    mis_d   = in_misalign;
                    cnt_d   = 3'd0;
                    // Faulted requests skip the memory access entirely.
                    state_d = (in_illegal || in_misalign) ? S_RESP : S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (op_is_load) begin
                    ld_wen = 1'b1;
                    raddr  = word_addr;
                    if (LOAD_LAT <= 1) begin
                        res_d   = extract(op_q, addr_q[1:0], rdata);
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = S_WAIT;
                    end
                end else begin
                    st_wen = 1'b1;
                    waddr  = word_addr;
                    case (op_q)
                        OP_SB: begin
                            wmask = {4'b0000, 4'b0001 << addr_q[1:0]};
                            wdata = {4{wdata_q[7:0]}};
                        end
                        OP_SH: begin
                            wmask = {4'b0000, 4'b0011 << addr_q[1:0]};
                            wdata = {2{wdata_q[15:0]}};
                        end
                        default: begin
                            wmask = 8'h0F;
                            wdata = wdata_q;
                        end
                    endcase
                    state_d = S_RESP;
                end
            end

            S_WAIT: begin
                // The last WAIT cycle ends on the rdata sample edge.
                if (cnt_q <= 3'd1) begin
                    res_d   = extract(op_q, addr_q[1:0], rdata);
                    cnt_d   = 3'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            S_RESP: begin
                out_valid    = 1'b1;
                out_rdata    = res_q;
                out_misalign = mis_q;
                out_illegal  = ill_q;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl (LOAD_LAT=3): directed and random requests
// compared against a behavioural model of the load/store rules; the bench
// drives rdata with the memory word only during the single expected sample
// cycle so any other sample point yields a wrong result.
module tb_lsu_ctrl;

    localparam int LAT = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'd0;
    logic [31:0] in_addr = 32'd0;
    logic [31:0] in_wdata = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic        out_misalign;
    logic        out_illegal;
    logic        ld_wen;
    logic [31:0] raddr;
    logic [31:0] rdata = 32'd0;
    logic        st_wen;
    logic [7:0]  wmask;
    logic [31:0] waddr;
    logic [31:0] wdata;

    int checks   = 0;
    int failures = 0;

    lsu_ctrl #(.LOAD_LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_misalign(out_misalign), .out_illegal(out_illegal),
        .ld_wen(ld_wen), .raddr(raddr), .rdata(rdata),
        .st_wen(st_wen), .wmask(wmask), .waddr(waddr), .wdata(wdata)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        ill;
        logic        mis;
        logic        ld;
        logic        st;
        logic [31:0] rd;
        logic [7:0]  wm;
        logic [31:0] wd;
    } exp_t;

    // Expected behaviour of one request, from the op table and byte arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [31:0] word);
        exp_t e;
        int nbytes;
        int off;
        int v;
        logic [31:0] s;
        e = '0;
        off = int'(addr % 4);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd5: e.ld = 1'b1;
            4'd8, 4'd9, 4'd10:            e.st = 1'b1;
            default:                      e.ill = 1'b1;
        endcase
        nbytes = 1 << (op % 4);
        if (!e.ill) e.mis = (addr % nbytes) != 0;
        if (e.ld && !e.mis) begin
            s = word >> (8 * off);
            case (op)
                4'd0: begin v = int'(s & 32'hFF); if (v >= 128) v -= 256; e.rd = 32'(v); end
                4'd4: e.rd = s & 32'hFF;
                4'd1: begin v = int'(s & 32'hFFFF); if (v >= 32768) v -= 65536; e.rd = 32'(v); end
                4'd5: e.rd = s & 32'hFFFF;
                default: e.rd = word;
            endcase
        end
        if (e.st && !e.mis) begin
            e.wm = 8'(((1 << nbytes) - 1) << off);
            if (nbytes == 1)      e.wd = (wd & 32'hFF) * 32'h01010101;
            else if (nbytes == 2) e.wd = (wd & 32'hFFFF) * 32'h00010001;
            else                  e.wd = wd;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".ld_wen"}, 32'(ld_wen), 32'd0);
        check({tag, ".st_wen"}, 32'(st_wen), 32'd0);
        check({tag, ".raddr"},  raddr, 32'd0);
        check({tag, ".waddr"},  waddr, 32'd0);
        check({tag, ".wmask"},  32'(wmask), 32'd0);
        check({tag, ".wdata"},  wdata, 32'd0);
    endtask

    // One complete request; starts and ends at a falling clock edge.
    task automatic do_req(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] word, input int bp);
        exp_t e;
        e = model(op, addr, wd, word);
        in_valid = 1'b1;
        in_op    = op;
        in_addr  = addr;
        in_wdata = wd;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        check({tag, ".idle_ov"},  32'(out_valid), 32'd0);
        @(negedge clock);
        in_valid = 1'b0;
        in_op    = 4'($urandom);
        in_addr  = $urandom;
        in_wdata = $urandom;
        if (e.ill || e.mis) begin
            check_quiet({tag, ".fault"});
        end else if (e.ld) begin
            for (int j = 0; j < LAT; j++) begin
                rdata = (j == LAT - 1) ? word : $urandom;
                check({tag, ".ld_wen"}, 32'(ld_wen), (j == 0) ? 32'd1 : 32'd0);
                check({tag, ".raddr"},  raddr, (j == 0) ? (addr & ~32'd3) : 32'd0);
                check({tag, ".ld_st"},  32'(st_wen), 32'd0);
                check({tag, ".ld_ov"},  32'(out_valid), 32'd0);
                @(negedge clock);
            end
            rdata = $urandom;
        end else begin
            check({tag, ".st_wen"}, 32'(st_wen), 32'd1);
            check({tag, ".waddr"},  waddr, addr & ~32'd3);
            check({tag, ".wmask"},  32'(wmask), 32'(e.wm));
            check({tag, ".wdata"},  wdata, e.wd);
            check({tag, ".st_ld"},  32'(ld_wen), 32'd0);
            @(negedge clock);
        end
        for (int k = 0; k <= bp; k++) begin
            if (k == bp) out_ready = 1'b1;
            check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".resp_rdy"},  32'(in_ready), 32'd0);
            check({tag, ".rdata"},     out_rdata, e.rd);
            check({tag, ".misalign"},  32'(out_misalign), 32'(e.mis));
            check({tag, ".illegal"},   32'(out_illegal), 32'(e.ill));
            check({tag, ".resp_strb"}, 32'(ld_wen | st_wen), 32'd0);
            @(negedge clock);
        end
        out_ready = 1'b0;
        check({tag, ".done_ov"},  32'(out_valid), 32'd0);
        check({tag, ".done_rdy"}, 32'(in_ready), 32'd1);
    endtask

    logic [3:0] legal_ops [8] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};

    initial begin
        logic [3:0]  rop;
        logic [31:0] raddr_r;

        // Reset state while held low.
        #12;
        check("rst.in_ready",  32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_rdata", out_rdata, 32'd0);
        check("rst.flags",     32'({out_misalign, out_illegal}), 32'd0);
        check_quiet("rst");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Stores with lane placement.
        do_req("sw",  4'd10, 32'h80000004, 32'hDEADBEEF, 32'h0, 0);
        do_req("sb",  4'd8,  32'h80000003, 32'h000000A5, 32'h0, 1);
        do_req("sh",  4'd9,  32'h80000002, 32'h00001234, 32'h0, 0);

        // Load extraction from one memory word.
        do_req("lb0",  4'd0, 32'h100, 32'h0, 32'h80F07F81, 0);
        do_req("lbu0", 4'd4, 32'h100, 32'h0, 32'h80F07F81, 0);
        do_req("lb1",  4'd0, 32'h101, 32'h0, 32'h80F07F81, 0);
        do_req("lh2",  4'd1, 32'h102, 32'h0, 32'h80F07F81, 0);
        do_req("lhu2", 4'd5, 32'h102, 32'h0, 32'h80F07F81, 0);
        do_req("lw0",  4'd2, 32'h100, 32'h0, 32'h80F07F81, 0);

        // Faults and the byte-op non-fault corner.
        do_req("lw_mis", 4'd2,  32'h102, 32'h0, 32'h80F07F81, 0);
        do_req("ill3",   4'd3,  32'h101, 32'h0, 32'h80F07F81, 0);
        do_req("illF",   4'd15, 32'h100, 32'h0, 32'h80F07F81, 1);
        do_req("lb3",    4'd0,  32'h103, 32'h0, 32'h80F07F81, 0);
        do_req("sh_mis", 4'd9,  32'h101, 32'h5555, 32'h0, 0);

        // Back-pressure: hold the response for 5 cycles.
        do_req("bp_lh",  4'd1, 32'h102, 32'h0, 32'h80F07F81, 5);
        do_req("bp_sb",  4'd8, 32'h11, 32'hC3, 32'h0, 5);

        // Reset during WAIT aborts the load.
        in_valid = 1'b1; in_op = 4'd2; in_addr = 32'h200; in_wdata = 32'h0;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("rstw.in_ready",  32'(in_ready), 32'd1);
        check("rstw.out_valid", 32'(out_valid), 32'd0);
        check_quiet("rstw");
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rdata = $urandom;
            @(negedge clock);
            check("rstw.post_ov",   32'(out_valid), 32'd0);
            check("rstw.post_strb", 32'(ld_wen | st_wen), 32'd0);
            check("rstw.post_rdy",  32'(in_ready), 32'd1);
        end

        // Reset during RESP drops the held response.
        in_valid = 1'b1; in_op = 4'd3; in_addr = 32'h0;
        @(negedge clock);
        in_valid = 1'b0;
        check("rstr.pre_ov", 32'(out_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rstr.out_valid", 32'(out_valid), 32'd0);
        check("rstr.illegal",   32'(out_illegal), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rstr.post_ov", 32'(out_valid), 32'd0);

        do_req("after_rst", 4'd5, 32'h302, 32'h0, 32'hABCD1234, 0);

        // Random requests against the model.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) rop = 4'($urandom_range(0, 15));
            else rop = legal_ops[$urandom_range(0, 7)];
            raddr_r = $urandom;
            if ($urandom_range(0, 1) == 1) raddr_r[1:0] = 2'b00;
            do_req("rnd", rop, raddr_r, $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
